mix_tree_sequencer: RTL

//  Timed valve/mixer controller for a parametrised binary mixing tree of 2**DEPTH inlets.
//  On start: loads enabled inlets one at a time, runs each mixer level leaf-to-root, then

---
 rtl/mix_tree_pkg.sv | 23 ++
 rtl/mix_tree_timer.sv | 23 ++
 rtl/mix_tree_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mix_tree_pkg.sv
// Shared types and helpers for the mixing-tree sequencer: FSM state encoding,
// default sizing constants and the next-inlet search.
package mix_tree_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MIX, DISPENSE, DONE} state_t;

  localparam int DEF_DEPTH    = 6;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_DISP_CYC = 32;

  // Widest mask the search handles (DEPTH <= 8); narrower masks are zero-extended.
  localparam int MAX_IN = 256;

  // Index of the lowest set bit at or above 'from', or -1 if there is none.
  function automatic int lowest_set_from(input logic [MAX_IN-1:0] mask, input int from);
    int r;
    r = -1;
    for (int i = MAX_IN - 1; i >= 0; i--)
      if (mask[i] && i >= from) r = i;
    return r;
  endfunction

endpackage

// File: rtl/mix_tree_timer.sv
// Loadable down-counter shared by every timed phase. A load value of 0 is
// clamped to 1; expire marks the last cycle of the loaded interval.
module mix_tree_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (load)        cnt <= (load_val == '0) ? CNT_W'(1) : load_val;
    else if (cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/mix_tree_sequencer.sv
// Timed valve/mixer sequencer for a binary mixing tree of 2**DEPTH inlets:
// load each enabled inlet, mix leaf-to-root, dispense. Build with
// MIX_TREE_STATS_EN to get saturating run/abort counters.
module mix_tree_sequencer
  import mix_tree_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DISP_CYC = DEF_DISP_CYC,
  localparam int N_IN    = 2**DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_IN-1:0]  in_mask,
  input  logic [CNT_W-1:0] cfg_load_cyc,
  input  logic [CNT_W-1:0] cfg_mix_cyc,
  output logic [N_IN-1:0]  inlet_valve,
  output logic [DEPTH-1:0] level_mix,
  output logic             outlet_valve,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] run_count,
  output logic [CNT_W-1:0] abort_count
);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  mask_q;
  logic [CNT_W-1:0] load_q, mix_q;
  logic [DEPTH-1:0] idx_q, idx_d;
  logic [N_IN-1:0]  inlet_d;
  logic [DEPTH-1:0] level_d;
  logic             outlet_d, done_d, err_d, busy_d;
  logic             cap, t_load, t_exp, abort_take;
  logic [CNT_W-1:0] t_val;
  int               first_set, next_set;

  assign first_set = lowest_set_from(MAX_IN'(in_mask), 0);
  assign next_set  = lowest_set_from(MAX_IN'(mask_q), int'(idx_q) + 1);

  mix_tree_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_exp)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    inlet_d    = '0;
    level_d    = '0;
    outlet_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cap        = 1'b0;
    t_load     = 1'b0;
    t_val      = load_q;
    abort_take = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        if (|in_mask) begin
          cap     = 1'b1;
          state_d = LOAD;
          idx_d   = DEPTH'(first_set);
          inlet_d = N_IN'(1) << idx_d;
          t_load  = 1'b1;
          t_val   = cfg_load_cyc;
        end else begin
          err_d   = 1'b1;
        end
      end
      LOAD: if (abort) abort_take = 1'b1;
      else if (t_exp) begin
        t_load = 1'b1;
        if (next_set >= 0) begin
          idx_d   = DEPTH'(next_set);
          inlet_d = N_IN'(1) << idx_d;
          t_val   = load_q;
        end else begin
          state_d = MIX;
          level_d = DEPTH'(1) << (DEPTH - 1);
          t_val   = mix_q;
        end
      end else inlet_d = inlet_valve;
      // level_mix is one-hot, so walking toward the root is a right shift
      MIX: if (abort) abort_take = 1'b1;
      else if (t_exp) begin
        t_load = 1'b1;
        if (level_mix[0]) begin
          state_d  = DISPENSE;
          outlet_d = 1'b1;
          t_val    = CNT_W'(DISP_CYC);
        end else begin
          level_d  = level_mix >> 1;
          t_val    = mix_q;
        end
      end else level_d = level_mix;
      DISPENSE: if (abort) abort_take = 1'b1;
      else if (t_exp) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else outlet_d = 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_take) begin
      state_d  = IDLE;
      inlet_d  = '0;
      level_d  = '0;
      outlet_d = 1'b0;
      err_d    = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mask_q       <= '0;
      load_q       <= '0;
      mix_q        <= '0;
      inlet_valve  <= '0;
      level_mix    <= '0;
      outlet_valve <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      inlet_valve  <= inlet_d;
      level_mix    <= level_d;
      outlet_valve <= outlet_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
      if (cap) begin
        mask_q <= in_mask;
        load_q <= cfg_load_cyc;
        mix_q  <= cfg_mix_cyc;
      end
    end
  end

`ifdef MIX_TREE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count   <= '0;
      abort_count <= '0;
    end else begin
      if (done_d && run_count != '1)       run_count   <= run_count + CNT_W'(1);
      if (abort_take && abort_count != '1) abort_count <= abort_count + CNT_W'(1);
    end
  end
`else
  assign run_count   = '0;
  assign abort_count = '0;
`endif

endmodule
